// File: rtl/risc32_step_ctrl.sv
// Run/step/breakpoint controller for the Risc32 core: gates core progress via cpu_en
// and records {pc, instr} of every enabled cycle into a show-ahead trace FIFO.
module risc32_step_ctrl #(
    parameter int unsigned PC_W          = 32,
    parameter int unsigned INSTR_W       = 32,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned TRACE_DEPTH   = 16,
    parameter bit          STALL_ON_FULL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [CNT_W-1:0]   cmd_count,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    cpu_pc,
    input  logic [INSTR_W-1:0] cpu_instr,
    output logic               cpu_en,
    output logic               halted,
    output logic [CNT_W-1:0]   steps_done,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [PC_W-1:0]    trace_pc,
    output logic [INSTR_W-1:0] trace_instr,
    input  logic               trace_clr,
    output logic               trace_overflow
);

    localparam int unsigned AW = $clog2(TRACE_DEPTH);
    localparam logic [AW:0] FULL_CNT = TRACE_DEPTH[AW:0];

    typedef enum logic [1:0] {S_HALTED, S_COUNT, S_FREE} state_t;
    typedef enum logic [1:0] {OP_HALT, OP_STEP, OP_RUN_N, OP_RUN_BP} op_t;

    state_t           state;
    op_t              op;
    logic [CNT_W-1:0] remain;
    logic             bp_mask;

    logic [PC_W-1:0]    mem_pc    [TRACE_DEPTH];
    logic [INSTR_W-1:0] mem_instr [TRACE_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;

    logic accept, fifo_full, full_blk, bp_hit, push, pop, drop;

    assign op        = op_t'(cmd_op);
    assign cmd_ready = ~rst;
    assign accept    = cmd_valid & cmd_ready;
    assign fifo_full = (count == FULL_CNT);
    assign full_blk  = STALL_ON_FULL & fifo_full;
    assign bp_hit    = bp_en & (cpu_pc == bp_addr) & ~bp_mask;
    assign cpu_en    = ((state == S_COUNT) | ((state == S_FREE) & ~bp_hit)) & ~full_blk;
    assign halted    = (state == S_HALTED);

    // A full FIFO blocks the push even when the head is popped in the same cycle
    assign push = cpu_en & ~fifo_full;
    assign drop = cpu_en & fifo_full;
    assign pop  = trace_valid & trace_ready;

    assign trace_valid = (count != '0);
    assign trace_pc    = mem_pc[rd_ptr];
    assign trace_instr = mem_instr[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_HALTED;
            remain     <= '0;
            bp_mask    <= 1'b0;
            steps_done <= '0;
        end else begin
            if (cpu_en && steps_done != '1)
                steps_done <= steps_done + CNT_W'(1);
            case (state)
                S_HALTED: begin
                    if (accept && op != OP_HALT) begin
                        steps_done <= '0;
                        case (op)
                            OP_STEP: begin
                                state  <= S_COUNT;
                                remain <= CNT_W'(1);
                            end
                            OP_RUN_N: begin
                                if (cmd_count != '0) begin
                                    state  <= S_COUNT;
                                    remain <= cmd_count;
                                end
                            end
                            OP_RUN_BP: begin
                                state   <= S_FREE;
                                bp_mask <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_COUNT: begin
                    if (cpu_en) begin
                        remain <= remain - CNT_W'(1);
                        if (remain == CNT_W'(1))
                            state <= S_HALTED;
                    end
                    if (accept && op == OP_HALT)
                        state <= S_HALTED;
                end
                S_FREE: begin
                    // Masking the first cycle lets RUN_BP resume from a breakpoint PC
                    if (cpu_en)
                        bp_mask <= 1'b0;
                    if ((bp_hit && !full_blk) || (accept && op == OP_HALT))
                        state <= S_HALTED;
                end
                default: state <= S_HALTED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || trace_clr) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            trace_overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
            if (drop && !STALL_ON_FULL)
                trace_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= cpu_pc;
            mem_instr[wr_ptr] <= cpu_instr;
        end
    end

endmodule

// File: tb/tb_risc32_step_ctrl.sv
// Directed bench for risc32_step_ctrl: one 16-deep stalling instance plus 4-deep
// stalling and dropping instances sharing the host-side stimulus.
module tb_risc32_step_ctrl;

    localparam logic [31:0] IK = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, bp_en, trace_ready, trace_clr, pc_clr;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_count;
    logic [31:0] bp_addr;

    logic [31:0] pc_a, pc_b, pc_c, ins_a, ins_b, ins_c;
    logic [31:0] tpc_a, tpc_b, tpc_c, tins_a, tins_b, tins_c;
    logic [15:0] sd_a, sd_b, sd_c;
    logic        rdy_a, rdy_b, rdy_c, en_a, en_b, en_c, h_a, h_b, h_c;
    logic        tv_a, tv_b, tv_c, ov_a, ov_b, ov_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (pc_clr) pc_a <= '0; else if (en_a) pc_a <= pc_a + 1;
    always @(posedge clk) if (pc_clr) pc_b <= '0; else if (en_b) pc_b <= pc_b + 1;
    always @(posedge clk) if (pc_clr) pc_c <= '0; else if (en_c) pc_c <= pc_c + 1;
    assign ins_a = pc_a ^ IK;
    assign ins_b = pc_b ^ IK;
    assign ins_c = pc_c ^ IK;

    risc32_step_ctrl dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy_a), .cmd_op(cmd_op),
        .cmd_count(cmd_count), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_pc(pc_a),
        .cpu_instr(ins_a), .cpu_en(en_a), .halted(h_a), .steps_done(sd_a),
        .trace_valid(tv_a), .trace_ready(trace_ready), .trace_pc(tpc_a),
        .trace_instr(tins_a), .trace_clr(trace_clr), .trace_overflow(ov_a)
    );

    risc32_step_ctrl #(.TRACE_DEPTH(4), .STALL_ON_FULL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy_b), .cmd_op(cmd_op),
        .cmd_count(cmd_count), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_pc(pc_b),
        .cpu_instr(ins_b), .cpu_en(en_b), .halted(h_b), .steps_done(sd_b),
        .trace_valid(tv_b), .trace_ready(trace_ready), .trace_pc(tpc_b),
        .trace_instr(tins_b), .trace_clr(trace_clr), .trace_overflow(ov_b)
    );

    risc32_step_ctrl #(.TRACE_DEPTH(4), .STALL_ON_FULL(1'b0)) dut_c (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy_c), .cmd_op(cmd_op),
        .cmd_count(cmd_count), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_pc(pc_c),
        .cpu_instr(ins_c), .cpu_en(en_c), .halted(h_c), .steps_done(sd_c),
        .trace_valid(tv_c), .trace_ready(trace_ready), .trace_pc(tpc_c),
        .trace_instr(tins_c), .trace_clr(trace_clr), .trace_overflow(ov_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] n);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = n;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n_b, n_c, pops;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = '0;
        bp_en = 1'b0; bp_addr = '0; trace_ready = 1'b0; trace_clr = 1'b0; pc_clr = 1'b1;
        tick(); tick();
        chk("rst_halted", h_a, 1);
        chk("rst_cpu_en", en_a, 0);
        chk("rst_trace_valid", tv_a, 0);
        chk("rst_steps", sd_a, 0);
        chk("rst_overflow", ov_a, 0);
        chk("rst_cmd_ready_low", rdy_a, 0);
        rst = 1'b0; pc_clr = 1'b0;
        #1;
        chk("cmd_ready_high", rdy_a, 1);

        // 1: three single steps, then drain trace
        for (int i = 0; i < 3; i++) begin
            issue(2'b01, 16'd0);
            chk("t1_step_en", en_a, 1);
            chk("t1_step_pc", pc_a, 32'(i));
            tick();
            chk("t1_step_off", en_a, 0);
            chk("t1_halted", h_a, 1);
        end
        chk("t1_steps_done", sd_a, 1);
        trace_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_trace_valid", tv_a, 1);
            chk("t1_trace_pc", tpc_a, 32'(i));
            chk("t1_trace_instr", tins_a, 32'(i) ^ IK);
            tick();
        end
        chk("t1_trace_empty", tv_a, 0);

        // 2: RUN_N 5
        issue(2'b10, 16'd5);
        chk("t2_steps_cleared", sd_a, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t2_run_en", en_a, 1);
            tick();
        end
        chk("t2_en_off", en_a, 0);
        chk("t2_halted", h_a, 1);
        chk("t2_steps_done", sd_a, 5);

        // 3: breakpoint at pc 12, then resume from it
        pc_clr = 1'b1; tick(); pc_clr = 1'b0;
        bp_en = 1'b1; bp_addr = 32'd12;
        issue(2'b11, 16'd0);
        chk("t3_free_running", h_a, 0);
        for (int i = 0; i < 40 && !h_a; i++) tick();
        chk("t3_bp_halted", h_a, 1);
        chk("t3_bp_pc", pc_a, 12);
        chk("t3_bp_steps", sd_a, 12);
        chk("t3_bp_en_off", en_a, 0);
        issue(2'b11, 16'd0);
        chk("t3_resume_en", en_a, 1);
        tick();
        chk("t3_resume_pc", pc_a, 13);
        chk("t3_resume_running", en_a, 1);
        issue(2'b00, 16'd0);
        chk("t3_halt_pc", pc_a, 14);
        chk("t3_halt_halted", h_a, 1);
        chk("t3_halt_steps", sd_a, 2);
        bp_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t3_trace_drained", tv_a, 0);

        // 5: HALT on the 7th enabled cycle of RUN_N 100
        trace_ready = 1'b0;
        issue(2'b10, 16'd100);
        for (int i = 0; i < 6; i++) tick();
        chk("t5_seventh_en", en_a, 1);
        issue(2'b00, 16'd0);
        chk("t5_halted", h_a, 1);
        chk("t5_steps", sd_a, 7);
        chk("t5_head_pc", tpc_a, 14);
        trace_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            if (tv_a) pops++;
            tick();
        end
        chk("t5_entries", pops, 7);

        // 4: 4-deep FIFO, stalling vs dropping
        rst = 1'b1; pc_clr = 1'b1; trace_ready = 1'b0;
        tick();
        rst = 1'b0; pc_clr = 1'b0;
        issue(2'b10, 16'd10);
        n_b = 0; n_c = 0;
        for (int i = 0; i < 20; i++) begin
            if (en_b) n_b++;
            if (en_c) n_c++;
            tick();
        end
        chk("t4_stall_steps", n_b, 4);
        chk("t4_stall_running", h_b, 0);
        chk("t4_stall_sd", sd_b, 4);
        chk("t4_drop_steps", n_c, 10);
        chk("t4_drop_halted", h_c, 1);
        chk("t4_drop_sd", sd_c, 10);
        chk("t4_drop_overflow", ov_c, 1);
        chk("t4_drop_head", tpc_c, 0);
        chk("t4_stall_no_ovf", ov_b, 0);
        trace_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 60 && pops < 10; i++) begin
            if (tv_b) begin
                chk("t4_order", tpc_b, 32'(pops));
                pops++;
            end
            tick();
        end
        chk("t4_stall_total", pops, 10);
        chk("t4_stall_done", h_b, 1);
        chk("t4_stall_sd_final", sd_b, 10);
        chk("t4_drop_ovf_sticky", ov_c, 1);
        trace_clr = 1'b1; tick(); trace_clr = 1'b0;
        chk("t4_clr_overflow", ov_c, 0);
        chk("t4_clr_empty", tv_c, 0);

        // 6: RUN_N 0 is a no-op; reset aborts a run
        issue(2'b10, 16'd0);
        chk("t6_zero_en", en_a, 0);
        chk("t6_zero_halted", h_a, 1);
        chk("t6_zero_steps", sd_a, 0);
        tick();
        chk("t6_zero_still_off", en_a, 0);
        trace_ready = 1'b0;
        issue(2'b10, 16'd50);
        tick(); tick();
        chk("t6_run_tv", tv_a, 1);
        chk("t6_run_en", en_a, 1);
        rst = 1'b1;
        tick();
        chk("t6_rst_en", en_a, 0);
        chk("t6_rst_tv", tv_a, 0);
        chk("t6_rst_halted", h_a, 1);
        chk("t6_rst_steps", sd_a, 0);
        rst = 1'b0;
        tick();
        chk("t6_after_rst_en", en_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
